// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two line-fill requesters, the arbiter and the memory port.
// slave = arbiter view, master = requester/memory-side view.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
);
    logic                            i_req;
    logic [WORD_SIZE-1:0]            i_addr;
    logic                            i_gnt;
    logic [WORD_SIZE-1:0]            i_rdata;
    logic                            i_rvalid;
    logic                            i_done;

    logic                            d_req;
    logic                            d_we;
    logic [WORD_SIZE-1:0]            d_addr;
    logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata;
    logic                            d_gnt;
    logic [WORD_SIZE-1:0]            d_rdata;
    logic                            d_rvalid;
    logic                            d_done;

    logic                            mem_req;
    logic                            mem_we;
    logic [WORD_SIZE-1:0]            mem_addr;
    logic [WORD_SIZE-1:0]            mem_wdata;
    logic [WORD_SIZE-1:0]            mem_rdata;
    logic                            mem_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_gnt, i_rdata, i_rvalid, i_done,
        output d_gnt, d_rdata, d_rvalid, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_gnt, i_rdata, i_rvalid, i_done,
        input  d_gnt, d_rdata, d_rvalid, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between I-fill and D-fill/writeback, one line per grant.
// Grant to first beat is one cycle; each beat waits for mem_ack; one DONE + one IDLE cycle between lines.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LINE_WORDS   = 4,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BW-1:0]        LAST_BEAT  = BW'(LINE_WORDS - 1);
    localparam logic [SW-1:0]        STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [WORD_SIZE-1:0] LINE_MASK  = ~WORD_SIZE'(LINE_WORDS - 1);

    logic [1:0]           state_q, state_d;
    logic                 own_d_q, own_d_d;
    logic [WORD_SIZE-1:0] base_q, base_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] word_q [LINE_WORDS];
    logic [WORD_SIZE-1:0] word_d [LINE_WORDS];
    logic [BW-1:0]        beat_q, beat_d;
    logic [SW-1:0]        streak_q, streak_d;

    logic grant_d, grant_i;
    logic xfer, done_st, rd_beat;

    // D wins a contested grant until it has won STARVE_LIMIT in a row over a waiting I.
    assign grant_d = bus.d_req && (!bus.i_req || (streak_q < STREAK_MAX));
    assign grant_i = bus.i_req && !grant_d;

    always_comb begin
        state_d  = state_q;
        own_d_d  = own_d_q;
        base_d   = base_q;
        we_d     = we_q;
        word_d   = word_q;
        beat_d   = beat_q;
        streak_d = streak_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d || grant_i) begin
                    state_d = ST_XFER;
                    own_d_d = grant_d;
                    base_d  = (grant_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
                    we_d    = grant_d && bus.d_we;
                    beat_d  = '0;
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        word_d[k] = bus.d_wdata[k*WORD_SIZE +: WORD_SIZE];
                    end
                    if (grant_d && bus.i_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            ST_XFER: begin
                if (bus.mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            own_d_q  <= 1'b0;
            base_q   <= '0;
            we_q     <= 1'b0;
            beat_q   <= '0;
            streak_q <= '0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                word_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            base_q   <= base_d;
            we_q     <= we_d;
            beat_q   <= beat_d;
            streak_q <= streak_d;
            word_q   <= word_d;
        end
    end

    assign xfer    = (state_q == ST_XFER);
    assign done_st = (state_q == ST_DONE);
    assign rd_beat = xfer && bus.mem_ack && !we_q;

    assign bus.mem_req   = xfer;
    assign bus.mem_we    = xfer && we_q;
    assign bus.mem_addr  = xfer ? base_q + WORD_SIZE'(beat_q) : '0;
    assign bus.mem_wdata = xfer ? word_q[beat_q] : '0;

    assign bus.i_gnt    = (xfer || done_st) && !own_d_q;
    assign bus.d_gnt    = (xfer || done_st) && own_d_q;
    assign bus.i_rvalid = rd_beat && !own_d_q;
    assign bus.d_rvalid = rd_beat && own_d_q;
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
    assign bus.i_done   = done_st && !own_d_q;
    assign bus.d_done   = done_st && own_d_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder with configurable wait, per-cycle output vectors.
module tb_mem_port_arbiter;
    localparam logic [15:0] K = 16'hC3A5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   mem_wait = 0;
    int   wait_cnt = 0;

    mem_port_arbiter_if #(.WORD_SIZE(16), .LINE_WORDS(4)) ifc ();

    mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4), .STARVE_LIMIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // {i_gnt,i_rvalid,i_rdata,i_done, d_gnt,d_rvalid,d_rdata,d_done, mem_req,mem_we,mem_addr,mem_wdata}
    function automatic logic [71:0] mk(input logic ig, input logic iv, input logic [15:0] ird, input logic idn,
                                       input logic dg, input logic dv, input logic [15:0] drd, input logic ddn,
                                       input logic mr, input logic mw, input logic [15:0] ma, input logic [15:0] mwd);
        return {ig, iv, ird, idn, dg, dv, drd, ddn, mr, mw, ma, mwd};
    endfunction

    function automatic logic [71:0] obs();
        return {ifc.i_gnt, ifc.i_rvalid, ifc.i_rdata, ifc.i_done,
                ifc.d_gnt, ifc.d_rvalid, ifc.d_rdata, ifc.d_done,
                ifc.mem_req, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata};
    endfunction

    // One clock: memory responder reacts 1ns after the edge, outputs are sampled 2ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ifc.mem_req) begin
            if (wait_cnt >= mem_wait) begin
                ifc.mem_ack   = 1'b1;
                ifc.mem_rdata = ifc.mem_addr ^ K;
                wait_cnt      = 0;
            end else begin
                ifc.mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            ifc.mem_ack   = 1'b0;
            ifc.mem_rdata = 16'h0;
            wait_cnt      = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [71:0] o;
        reset = 1'b1;
        tick(); tick();
        o = obs(); checks++;
        if (o !== 72'h0) $display("FAIL reset_idle: got %h want %h", o, 72'h0); else passed++;
        ifc.i_req = 1'b1; ifc.d_req = 1'b1;
        tick();
        o = obs(); checks++;
        if (o !== 72'h0) $display("FAIL reset_holds: got %h want %h", o, 72'h0); else passed++;
        ifc.i_req = 1'b0; ifc.d_req = 1'b0; reset = 1'b0;
        tick();
        o = obs(); checks++;
        if (o !== 72'h0) $display("FAIL reset_release: got %h want %h", o, 72'h0); else passed++;
    endtask

    task automatic test_i_fill();
        logic [71:0] o, e;
        logic [15:0] a;
        ifc.i_req = 1'b1; ifc.i_addr = 16'h0013;
        for (int k = 0; k < 4; k++) begin
            tick();
            a = 16'h0010 + 16'(k);
            e = mk(1, 1, a ^ K, 0, 0, 0, 0, 0, 1, 0, a, 0);
            o = obs(); checks++;
            if (o !== e) $display("FAIL ifill_beat%0d: got %h want %h", k, o, e); else passed++;
        end
        tick();
        e = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        o = obs(); checks++;
        if (o !== e) $display("FAIL ifill_done: got %h want %h", o, e); else passed++;
        ifc.i_req = 1'b0;
        tick();
        o = obs(); checks++;
        if (o !== 72'h0) $display("FAIL ifill_idle: got %h want %h", o, 72'h0); else passed++;
    endtask

    task automatic test_contention();
        logic [71:0] o, e;
        logic [15:0] a;
        ifc.i_req = 1'b1; ifc.i_addr = 16'h0200;
        ifc.d_req = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 16'h0040;
        for (int k = 0; k < 4; k++) begin
            tick();
            a = 16'h0040 + 16'(k);
            e = mk(0, 0, 0, 0, 1, 1, a ^ K, 0, 1, 0, a, 0);
            o = obs(); checks++;
            if (o !== e) $display("FAIL cont_d_beat%0d: got %h want %h", k, o, e); else passed++;
        end
        tick();
        e = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        o = obs(); checks++;
        if (o !== e) $display("FAIL cont_d_done: got %h want %h", o, e); else passed++;
        ifc.d_req = 1'b0;
        tick();
        o = obs(); checks++;
        if (o !== 72'h0) $display("FAIL cont_gap: got %h want %h", o, 72'h0); else passed++;
        for (int k = 0; k < 4; k++) begin
            tick();
            a = 16'h0200 + 16'(k);
            e = mk(1, 1, a ^ K, 0, 0, 0, 0, 0, 1, 0, a, 0);
            o = obs(); checks++;
            if (o !== e) $display("FAIL cont_i_beat%0d: got %h want %h", k, o, e); else passed++;
        end
        tick();
        ifc.i_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [1:0]  o, e;
        logic        own_d;
        logic [15:0] base;
        logic [3:0]  order = 4'b1011;  // grant g is D when order[g]
        ifc.i_req = 1'b1; ifc.i_addr = 16'h0300;
        ifc.d_req = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 16'h0400;
        for (int g = 0; g < 4; g++) begin
            own_d = order[g];
            base  = own_d ? 16'h0400 : 16'h0300;
            tick();
            e = {!own_d, own_d};
            o = {ifc.i_gnt, ifc.d_gnt}; checks++;
            if (o !== e || ifc.mem_addr !== base)
                $display("FAIL starve_grant%0d: got gnt=%b addr=%h want gnt=%b addr=%h", g, o, ifc.mem_addr, e, base);
            else passed++;
            tick(); tick(); tick();
            tick();
            o = {ifc.i_done, ifc.d_done}; checks++;
            if (o !== e) $display("FAIL starve_done%0d: got %b want %b", g, o, e); else passed++;
            if (g == 3) begin
                ifc.i_req = 1'b0; ifc.d_req = 1'b0;
            end
            tick();
            o = {ifc.i_gnt, ifc.d_gnt}; checks++;
            if (o !== 2'b00 || ifc.mem_req !== 1'b0)
                $display("FAIL starve_gap%0d: got gnt=%b mem_req=%b want gnt=00 mem_req=0", g, o, ifc.mem_req);
            else passed++;
        end
    endtask

    task automatic test_d_write();
        logic [71:0] o, e;
        logic [15:0] wd [4];
        wd[0] = 16'hAAAA; wd[1] = 16'hBBBB; wd[2] = 16'hCCCC; wd[3] = 16'hDDDD;
        mem_wait = 3;
        ifc.d_req = 1'b1; ifc.d_we = 1'b1; ifc.d_addr = 16'h0100;
        ifc.d_wdata = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 4; w++) begin
                tick();
                e = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 16'h0100 + 16'(k), wd[k]);
                o = obs(); checks++;
                if (o !== e) $display("FAIL dwr_beat%0d_cyc%0d: got %h want %h", k, w, o, e); else passed++;
            end
        end
        tick();
        e = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        o = obs(); checks++;
        if (o !== e) $display("FAIL dwr_done: got %h want %h", o, e); else passed++;
        ifc.d_req = 1'b0; ifc.d_we = 1'b0; ifc.d_wdata = '0;
        mem_wait = 0;
        tick();
        o = obs(); checks++;
        if (o !== 72'h0) $display("FAIL dwr_idle: got %h want %h", o, 72'h0); else passed++;
    endtask

    task automatic test_wrap();
        logic [71:0] o, e;
        logic [15:0] a;
        ifc.d_req = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 16'hFFFE;
        for (int k = 0; k < 4; k++) begin
            tick();
            a = 16'hFFFC + 16'(k);
            e = mk(0, 0, 0, 0, 1, 1, a ^ K, 0, 1, 0, a, 0);
            o = obs(); checks++;
            if (o !== e) $display("FAIL wrap_beat%0d: got %h want %h", k, o, e); else passed++;
        end
        tick();
        o = {ifc.d_done, ifc.mem_req}; checks++;
        if (o !== 2'b10) $display("FAIL wrap_done: got %b want %b", o, 2'b10); else passed++;
        ifc.d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [71:0] o, e;
        logic [15:0] a;
        ifc.i_req = 1'b1; ifc.i_addr = 16'h0500;
        tick(); tick(); tick();
        o = {56'h0, ifc.mem_addr}; checks++;
        if (o !== 72'h0502) $display("FAIL rmid_beat2: got %h want %h", o, 72'h0502); else passed++;
        reset = 1'b1; ifc.i_req = 1'b0;
        tick();
        o = obs(); checks++;
        if (o !== 72'h0) $display("FAIL rmid_abort: got %h want %h", o, 72'h0); else passed++;
        reset = 1'b0; ifc.i_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            a = 16'h0500 + 16'(k);
            e = mk(1, 1, a ^ K, 0, 0, 0, 0, 0, 1, 0, a, 0);
            o = obs(); checks++;
            if (o !== e) $display("FAIL rmid_restart%0d: got %h want %h", k, o, e); else passed++;
        end
        tick();
        e = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        o = obs(); checks++;
        if (o !== e) $display("FAIL rmid_done: got %h want %h", o, e); else passed++;
        ifc.i_req = 1'b0;
        tick();
    endtask

    initial begin
        ifc.i_req = 1'b0; ifc.i_addr = '0;
        ifc.d_req = 1'b0; ifc.d_we = 1'b0; ifc.d_addr = '0; ifc.d_wdata = '0;
        ifc.mem_rdata = '0; ifc.mem_ack = 1'b0;
        test_reset();
        test_i_fill();
        test_contention();
        test_starvation();
        test_d_write();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
